nasti_burst_master: RTL and testbench
=====================================

# nasti_burst_master

Single-outstanding NASTI (AXI4) initiator that turns a simple command/stream interface into AXI INCR bursts on the aw/w/b/ar/r channels. It is the master-side counterpart of the behavioural memory slaves and DMA-style test targets. Test engines, boot loaders and bench drivers use it to move data to and from any NASTI slave without handling AXI handshakes themselves.

## Interface
Parameters:
- ID_WIDTH, 1, width of AXI id fields (≤16)
- ADDR_WIDTH, 16, byte address width (≤32)
- DATA_WIDTH, 128, data bus width, power of two, 8..256
- USER_WIDTH, 1, width of AXI user fields; driven 0

Ports:
- clk  in  1  single clock; all logic on posedge
- rstn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high; equals (state==IDLE)
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_WIDTH  burst start byte address, aligned to DATA_WIDTH/8
- cmd_len  in  8  AXI len (beats−1)
- cmd_id  in  ID_WIDTH  AXI id for the burst
- wd_valid / wd_ready  in / out  1  write-data stream handshake
- wd_data  in  DATA_WIDTH  write beat
- wd_strb  in  DATA_WIDTH/8  byte enables
- rd_valid / rd_ready  out / in  1  read-data stream handshake
- rd_data  out  DATA_WIDTH  read beat
- rd_last  out  1  final beat of the burst
- done_valid  out  1  one-cycle pulse at burst completion
- done_resp  out  2  completion status (OKAY=0, SLVERR=2, DECERR=3)
- aw, w, b, ar, r  nasti_aw/w/b/ar/r.master  AXI channels

## Operation
- States: IDLE, AW, WD, WB, AR, RD.
- IDLE: cmd handshake latches addr/len/id/write and clears beat counter and error. Next state is AW (write) or AR (read).
- AW/AR: valid is registered high; id/addr/len are from latched cmd. size = log2(DATA_WIDTH/8), burst = INCR (2'b01), user = 0, lock/cache/prot/qos/region = 0.
  - valid and all payload stay stable until ready; AXI no-retract rule applies.
  - On handshake: AW→WD, AR→RD.
- WD: combinational pass-through.
  - w.valid = wd_valid, wd_ready = w.ready, w.data/w.strb = wd_*, w.user = 0.
  - w.last = (beat == len).
  - Each w handshake increments the 8-bit beat counter.
  - Handshake with last → WB.
- WB: b.ready = 1.
  - On handshake, done_resp ← b.resp, or SLVERR if b.id ≠ latched id.
  - done_valid pulses; state → IDLE.
- RD: pass-through.
  - rd_valid = r.valid, r.ready = rd_ready, rd_data/rd_last = r.data/r.last.
  - Error is sticky: the first beat with r.resp ≠ OKAY, or r.id ≠ latched id, sets error to that resp (SLVERR for an id mismatch).
  - Handshake with r.last → done_resp = error (OKAY if none), done_valid pulse, IDLE.
  - Beat counter counts r beats. If r.last arrives with beat ≠ len, or beat == len without r.last, done_resp = SLVERR. The burst still ends on r.last only.
- Outside WD: wd_ready = 0, w.valid = 0. Outside RD: rd_valid = 0, r.ready = 0. Outside WB: b.ready = 0.
- Reset (any time, including mid-burst): state IDLE. aw.valid, ar.valid, w.valid, b.ready, r.ready, done_valid, rd_valid, wd_ready = 0. done_resp = 0; counters and latches cleared. An interrupted slave transaction is not recovered.

## Timing
- cmd handshake in cycle N → aw.valid/ar.valid high in N+1.
- AW handshake in cycle M → w.valid may follow wd_valid from M+1. No W beat is issued before AW completes.
- Best-case write of L+1 beats: cmd N, AW N+1, W N+2..N+2+L, B at N+3+L, done_valid at N+4+L, cmd_ready at N+4+L.
- Best-case read: cmd N, AR N+1. Last r beat in cycle K → done_valid and cmd_ready in K+1.
- done_valid is high for exactly one cycle. done_resp holds its value until the next completion.
- No combinational path from cmd_* to any AXI output. W/R data paths are combinational pass-through by design.
- Beat counter wraps at 256 only with len = 255. Last beat is beat 255; no overflow state.

## Test plan
- Single-beat write: cmd_write=1, addr=0x40, len=0, id=1; slave ready always, b.resp=0. Expect aw.addr=0x40, aw.len=0, aw.size=4 (128-bit), w.last=1 on the only beat, done_valid one cycle with done_resp=0, 4 cycles cmd→done.
- 4-beat write with wd_valid gaps and aw.ready held low 5 cycles. Expect aw.valid and payload stable throughout, no w.valid before AW handshake, w.last only on beat 3, 4 w handshakes.
- 4-beat read with rd_ready toggling 1,0,1,0. Expect r.ready to mirror rd_ready, 4 data beats delivered in order, rd_last on beat 3, done_resp=0.
- Read with r.resp=SLVERR on beat 1 of 4, OKAY elsewhere. Expect done_resp=2. Separately, r.id≠cmd_id gives done_resp=2; b.resp=3 on a write gives done_resp=3.
- rstn low during write beat 2 of 4. Expect all valids/readies 0 asynchronously, cmd_ready=1 after release, and a following read burst completes normally.
- len=255 read. Expect 256 beats and correct rd_last; r.last early at beat 100 gives done_resp=2 and return to IDLE.

Source files
------------

// File: rtl/nasti_burst_master_if.sv
// nasti_burst_master_if: NASTI (AXI4) channel bundles, one interface per channel.
interface nasti_aw #(parameter int ID_WIDTH = 1, parameter int ADDR_WIDTH = 16, parameter int USER_WIDTH = 1);
   logic                  valid, ready;
   logic [ID_WIDTH-1:0]   id;
   logic [ADDR_WIDTH-1:0] addr;
   logic [7:0]            len;
   logic [2:0]            size;
   logic [1:0]            burst;
   logic                  lock;
   logic [3:0]            cache;
   logic [2:0]            prot;
   logic [3:0]            qos, region;
   logic [USER_WIDTH-1:0] user;
   modport master (output valid, id, addr, len, size, burst, lock, cache, prot, qos, region, user, input ready);
   modport slave (input valid, id, addr, len, size, burst, lock, cache, prot, qos, region, user, output ready);
endinterface

interface nasti_ar #(parameter int ID_WIDTH = 1, parameter int ADDR_WIDTH = 16, parameter int USER_WIDTH = 1);
   logic                  valid, ready;
   logic [ID_WIDTH-1:0]   id;
   logic [ADDR_WIDTH-1:0] addr;
   logic [7:0]            len;
   logic [2:0]            size;
   logic [1:0]            burst;
   logic                  lock;
   logic [3:0]            cache;
   logic [2:0]            prot;
   logic [3:0]            qos, region;
   logic [USER_WIDTH-1:0] user;
   modport master (output valid, id, addr, len, size, burst, lock, cache, prot, qos, region, user, input ready);
   modport slave (input valid, id, addr, len, size, burst, lock, cache, prot, qos, region, user, output ready);
endinterface

interface nasti_w #(parameter int DATA_WIDTH = 128, parameter int USER_WIDTH = 1);
   logic                    valid, ready, last;
   logic [DATA_WIDTH-1:0]   data;
   logic [DATA_WIDTH/8-1:0] strb;
   logic [USER_WIDTH-1:0]   user;
   modport master (output valid, data, strb, last, user, input ready);
   modport slave (input valid, data, strb, last, user, output ready);
endinterface

interface nasti_b #(parameter int ID_WIDTH = 1, parameter int USER_WIDTH = 1);
   logic                  valid, ready;
   logic [ID_WIDTH-1:0]   id;
   logic [1:0]            resp;
   logic [USER_WIDTH-1:0] user;
   modport master (input valid, id, resp, user, output ready);
   modport slave (output valid, id, resp, user, input ready);
endinterface

interface nasti_r #(parameter int ID_WIDTH = 1, parameter int DATA_WIDTH = 128, parameter int USER_WIDTH = 1);
   logic                  valid, ready, last;
   logic [ID_WIDTH-1:0]   id;
   logic [DATA_WIDTH-1:0] data;
   logic [1:0]            resp;
   logic [USER_WIDTH-1:0] user;
   modport master (input valid, id, data, resp, last, user, output ready);
   modport slave (output valid, id, data, resp, last, user, input ready);
endinterface

// File: rtl/nasti_burst_master.sv
// nasti_burst_master: single-outstanding NASTI initiator turning command/stream
// requests into INCR write or read bursts.
module nasti_burst_master #(
   parameter int ID_WIDTH   = 1,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 128,
   parameter int USER_WIDTH = 1
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [7:0]              cmd_len,
   input  logic [ID_WIDTH-1:0]     cmd_id,
   input  logic                    wd_valid,
   output logic                    wd_ready,
   input  logic [DATA_WIDTH-1:0]   wd_data,
   input  logic [DATA_WIDTH/8-1:0] wd_strb,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    rd_last,
   output logic                    done_valid,
   output logic [1:0]              done_resp,
   nasti_aw.master                 aw,
   nasti_w.master                  w,
   nasti_b.master                  b,
   nasti_ar.master                 ar,
   nasti_r.master                  r
);
   localparam logic [2:0] SIZE = 3'($clog2(DATA_WIDTH / 8));
   localparam logic [1:0] OKAY = 2'd0;
   localparam logic [1:0] SLVERR = 2'd2;
   typedef enum logic [2:0] {IDLE, AW, WD, WB, AR, RD} state_t;
   state_t                state, state_n;
   logic [ADDR_WIDTH-1:0] addr;
   logic [7:0]            len, beat;
   logic [ID_WIDTH-1:0]   id;
   logic [1:0]            err, r_err, b_resp;
   logic                  w_hs, b_hs, r_hs;

   assign cmd_ready = state == IDLE;
   assign aw.valid  = state == AW;
   assign aw.id     = id;
   assign aw.addr   = addr;
   assign aw.len    = len;
   assign aw.size   = SIZE;
   assign aw.burst  = 2'b01;
   assign aw.lock   = 1'b0;
   assign aw.cache  = '0;
   assign aw.prot   = '0;
   assign aw.qos    = '0;
   assign aw.region = '0;
   assign aw.user   = '0;
   assign ar.valid  = state == AR;
   assign ar.id     = id;
   assign ar.addr   = addr;
   assign ar.len    = len;
   assign ar.size   = SIZE;
   assign ar.burst  = 2'b01;
   assign ar.lock   = 1'b0;
   assign ar.cache  = '0;
   assign ar.prot   = '0;
   assign ar.qos    = '0;
   assign ar.region = '0;
   assign ar.user   = '0;
   assign w.valid   = state == WD && wd_valid;
   assign wd_ready  = state == WD && w.ready;
   assign w.data    = wd_data;
   assign w.strb    = wd_strb;
   assign w.last    = beat == len;
   assign w.user    = '0;
   assign b.ready   = state == WB;
   assign r.ready   = state == RD && rd_ready;
   assign rd_valid  = state == RD && r.valid;
   assign rd_data   = r.data;
   assign rd_last   = r.last;
   assign w_hs      = state == WD && wd_valid && w.ready;
   assign b_hs      = state == WB && b.valid;
   assign r_hs      = state == RD && rd_ready && r.valid;
   // First error wins; a beat-count/last disagreement counts as SLVERR.
   assign r_err  = err != OKAY ? err : r.resp != OKAY ? r.resp : r.id != id ? SLVERR :
                   r.last != (beat == len) ? SLVERR : OKAY;
   assign b_resp = b.id != id ? SLVERR : b.resp;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = cmd_valid ? (cmd_write ? AW : AR) : IDLE;
         AW:      state_n = aw.ready ? WD : AW;
         WD:      state_n = w_hs && w.last ? WB : WD;
         WB:      state_n = b_hs ? IDLE : WB;
         AR:      state_n = ar.ready ? RD : AR;
         RD:      state_n = r_hs && r.last ? IDLE : RD;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         addr       <= '0;
         len        <= '0;
         id         <= '0;
         beat       <= '0;
         err        <= OKAY;
         done_valid <= 1'b0;
         done_resp  <= OKAY;
      end else begin
         state      <= state_n;
         done_valid <= b_hs || (r_hs && r.last);
         if (cmd_valid && cmd_ready) begin
            addr <= cmd_addr;
            len  <= cmd_len;
            id   <= cmd_id;
            beat <= '0;
            err  <= OKAY;
         end
         if (w_hs || r_hs) beat <= beat + 8'd1;
         if (r_hs) err <= r_err;
         if (b_hs) done_resp <= b_resp;
         if (r_hs && r.last) done_resp <= r_err;
      end
   end
endmodule

// File: tb/tb_nasti_burst_master.sv
// tb_nasti_burst_master: directed self-checking bench acting as command source
// and NASTI slave for nasti_burst_master.
module tb_nasti_burst_master;
   localparam int IW = 2;
   localparam int AW_ = 16;
   localparam int DW = 128;
   localparam int UW = 1;

   logic            clk = 0;
   logic            rstn = 1;
   logic            cmd_valid = 0, cmd_ready, cmd_write = 0;
   logic [AW_-1:0]  cmd_addr = '0;
   logic [7:0]      cmd_len = '0;
   logic [IW-1:0]   cmd_id = '0;
   logic            wd_valid = 0, wd_ready;
   logic [DW-1:0]   wd_data = '0;
   logic [DW/8-1:0] wd_strb = '0;
   logic            rd_valid, rd_ready = 0, rd_last;
   logic [DW-1:0]   rd_data;
   logic            done_valid;
   logic [1:0]      done_resp;
   int              tests = 0, fails = 0;
   int              hs, rb;

   nasti_aw #(.ID_WIDTH(IW), .ADDR_WIDTH(AW_), .USER_WIDTH(UW)) aw_if ();
   nasti_w  #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) w_if ();
   nasti_b  #(.ID_WIDTH(IW), .USER_WIDTH(UW)) b_if ();
   nasti_ar #(.ID_WIDTH(IW), .ADDR_WIDTH(AW_), .USER_WIDTH(UW)) ar_if ();
   nasti_r  #(.ID_WIDTH(IW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) r_if ();

   nasti_burst_master #(.ID_WIDTH(IW), .ADDR_WIDTH(AW_), .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
      .clk(clk), .rstn(rstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
      .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
      .done_valid(done_valid), .done_resp(done_resp),
      .aw(aw_if), .w(w_if), .b(b_if), .ar(ar_if), .r(r_if)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] wdat(input int k);
      return {4{32'hA5A5_0000 + 32'(k)}};
   endfunction

   function automatic logic [DW-1:0] rdat(input int k);
      return {4{32'hC0DE_0000 + 32'(k)}};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic wr, input logic [AW_-1:0] a, input logic [7:0] l, input logic [IW-1:0] i);
      cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_id = i;
      #1;
      chk("cmd_ready", cmd_ready, 1);
      chk("no_comb_cmd", aw_if.valid | ar_if.valid, 0);
      tick();
      cmd_valid = 0; cmd_addr = '1; cmd_len = 8'h5a; cmd_id = ~i;
      chk("busy", cmd_ready, 0);
   endtask

   task automatic write_burst(input logic [AW_-1:0] a, input logic [7:0] l, input logic [IW-1:0] i,
                              input logic [IW-1:0] bid, input logic [1:0] bresp, input logic [1:0] exp);
      aw_if.ready = 1; w_if.ready = 1;
      issue(1, a, l, i);
      chk("aw_valid", aw_if.valid, 1);
      chk("aw_addr", aw_if.addr, a);
      chk("aw_len", aw_if.len, l);
      chk("aw_id", aw_if.id, i);
      chk("aw_size", aw_if.size, 4);
      chk("aw_burst", aw_if.burst, 1);
      chk("aw_misc", {aw_if.lock, aw_if.cache, aw_if.prot, aw_if.qos, aw_if.region, aw_if.user}, 0);
      tick();
      for (int k = 0; k <= int'(l); k++) begin
         wd_valid = 1; wd_data = wdat(k); wd_strb = '1;
         #1;
         chk("w_valid", w_if.valid, 1);
         chk("w_last", w_if.last, k == int'(l));
         chk("w_data", w_if.data, wdat(k));
         tick();
      end
      wd_valid = 0;
      b_if.valid = 1; b_if.id = bid; b_if.resp = bresp;
      #1;
      chk("b_ready", b_if.ready, 1);
      chk("wr_done_early", done_valid, 0);
      tick();
      b_if.valid = 0;
      #1;
      chk("wr_done", done_valid, 1);
      chk("wr_resp", done_resp, exp);
      chk("wr_idle", cmd_ready, 1);
      tick();
      chk("wr_done_pulse", done_valid, 0);
      chk("wr_resp_hold", done_resp, exp);
   endtask

   task automatic read_burst(input logic [AW_-1:0] a, input logic [7:0] l, input logic [IW-1:0] i,
                             input logic [IW-1:0] rid, input int err_beat, input logic [1:0] err_resp,
                             input int last_beat, input logic [1:0] exp);
      ar_if.ready = 1; rd_ready = 1;
      issue(0, a, l, i);
      chk("ar_valid", ar_if.valid, 1);
      chk("ar_addr", ar_if.addr, a);
      chk("ar_len", ar_if.len, l);
      chk("ar_id", ar_if.id, i);
      chk("ar_size", ar_if.size, 4);
      chk("ar_no_aw", aw_if.valid, 0);
      tick();
      for (int k = 0; k <= last_beat; k++) begin
         r_if.valid = 1; r_if.id = rid; r_if.data = rdat(k);
         r_if.resp = k == err_beat ? err_resp : 2'd0;
         r_if.last = k == last_beat;
         #1;
         chk("rd_valid", rd_valid, 1);
         chk("rd_data", rd_data, rdat(k));
         chk("rd_last", rd_last, k == last_beat);
         tick();
      end
      r_if.valid = 0; r_if.last = 0; r_if.resp = 0;
      #1;
      chk("rd_done", done_valid, 1);
      chk("rd_resp", done_resp, exp);
      chk("rd_idle", cmd_ready, 1);
      tick();
      chk("rd_done_pulse", done_valid, 0);
   endtask

   initial begin
      aw_if.ready = 0; w_if.ready = 0; ar_if.ready = 0;
      b_if.valid = 0; b_if.id = '0; b_if.resp = '0; b_if.user = '0;
      r_if.valid = 0; r_if.id = '0; r_if.data = '0; r_if.resp = '0; r_if.last = 0; r_if.user = '0;
      #1 rstn = 0;
      tick();
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_aw_valid", aw_if.valid, 0);
      chk("rst_ar_valid", ar_if.valid, 0);
      chk("rst_done", done_valid, 0);
      chk("rst_resp", done_resp, 0);
      rstn = 1;
      tick();

      // single-beat write, 4 cycles command to done
      write_burst(16'h0040, 0, 1, 1, 2'd0, 2'd0);

      // 4-beat write with AW stalled 5 cycles and gappy write data
      aw_if.ready = 0; w_if.ready = 1; wd_valid = 1; wd_data = wdat(0); wd_strb = '1;
      issue(1, 16'h0100, 3, 2);
      for (int k = 0; k < 5; k++) begin
         chk("aw_hold_valid", aw_if.valid, 1);
         chk("aw_hold_addr", aw_if.addr, 16'h0100);
         chk("aw_hold_len", aw_if.len, 3);
         chk("no_w_before_aw", w_if.valid, 0);
         chk("no_wd_ready_before_aw", wd_ready, 0);
         tick();
      end
      aw_if.ready = 1;
      #1 chk("aw_still_valid", aw_if.valid, 1);
      tick();
      aw_if.ready = 0;
      hs = 0;
      for (int k = 0; k < 12 && hs < 4; k++) begin
         wd_valid = k % 2 == 0; wd_data = wdat(hs);
         #1;
         chk("gap_w_valid", w_if.valid, wd_valid);
         if (wd_valid) chk("gap_w_last", w_if.last, hs == 3);
         chk("gap_w_data", w_if.data, wdat(hs));
         if (w_if.valid && w_if.ready) hs++;
         tick();
      end
      wd_valid = 0;
      chk("gap_w_beats", hs, 4);
      #1;
      chk("gap_w_idle", w_if.valid, 0);
      chk("gap_b_ready", b_if.ready, 1);
      b_if.valid = 1; b_if.id = 2; b_if.resp = 0;
      tick();
      b_if.valid = 0;
      #1;
      chk("gap_done", done_valid, 1);
      chk("gap_resp", done_resp, 0);
      tick();

      // 4-beat read with rd_ready toggling
      ar_if.ready = 1;
      issue(0, 16'h0200, 3, 1);
      chk("tog_ar_valid", ar_if.valid, 1);
      tick();
      rb = 0;
      for (int k = 0; k < 16 && rb < 4; k++) begin
         rd_ready = k % 2 == 0;
         r_if.valid = 1; r_if.id = 1; r_if.resp = 0; r_if.data = rdat(rb); r_if.last = rb == 3;
         #1;
         chk("tog_r_ready", r_if.ready, rd_ready);
         chk("tog_rd_valid", rd_valid, 1);
         chk("tog_rd_data", rd_data, rdat(rb));
         chk("tog_rd_last", rd_last, rb == 3);
         if (r_if.ready) rb++;
         tick();
      end
      r_if.valid = 0; r_if.last = 0;
      chk("tog_beats", rb, 4);
      #1;
      chk("tog_done", done_valid, 1);
      chk("tog_resp", done_resp, 0);
      tick();

      // error responses
      read_burst(16'h0400, 3, 1, 1, 1, 2'd2, 3, 2'd2);
      read_burst(16'h0500, 1, 1, 2, -1, 2'd0, 1, 2'd2);
      write_burst(16'h0600, 1, 2, 2, 2'd3, 2'd3);
      write_burst(16'h0700, 0, 1, 0, 2'd0, 2'd2);

      // reset during write beat 2 of 4
      aw_if.ready = 1; w_if.ready = 1; rd_ready = 1;
      issue(1, 16'h0300, 3, 1);
      tick();
      for (int k = 0; k < 2; k++) begin
         wd_valid = 1; wd_data = wdat(k);
         tick();
      end
      wd_data = wdat(2);
      #1 chk("pre_rst_w_valid", w_if.valid, 1);
      #1 rstn = 0;
      #1;
      chk("arst_w_valid", w_if.valid, 0);
      chk("arst_wd_ready", wd_ready, 0);
      chk("arst_aw_valid", aw_if.valid, 0);
      chk("arst_ar_valid", ar_if.valid, 0);
      chk("arst_b_ready", b_if.ready, 0);
      chk("arst_r_ready", r_if.ready, 0);
      chk("arst_rd_valid", rd_valid, 0);
      chk("arst_done", done_valid, 0);
      chk("arst_resp", done_resp, 0);
      chk("arst_cmd_ready", cmd_ready, 1);
      wd_valid = 0;
      tick();
      rstn = 1;
      tick();
      chk("post_rst_cmd_ready", cmd_ready, 1);
      read_burst(16'h0800, 3, 2, 2, -1, 2'd0, 3, 2'd0);

      // len=255 full burst, early last, missing last, then a clean burst
      read_burst(16'h1000, 255, 1, 1, -1, 2'd0, 255, 2'd0);
      read_burst(16'h2000, 255, 0, 0, -1, 2'd0, 100, 2'd2);
      read_burst(16'h3000, 1, 1, 1, -1, 2'd0, 2, 2'd2);
      read_burst(16'h3100, 0, 0, 0, -1, 2'd0, 0, 2'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
